// File: rtl/pcm_cond_pkg.sv
// pcm_cond_pkg
// Shared types, limits and saturation helpers for the PCM conditioning path.
//   pcm_sample_t : signed 16-bit PCM sample
//   PCM_MAX/MIN  : signed 16-bit limits
//   sat16        : clamp a 26-bit signed intermediate to the 16-bit range
//   abs_sat16    : magnitude of a sample, with |-32768| clamped to 32767
package pcm_cond_pkg;

    typedef logic signed [15:0] pcm_sample_t;

    localparam pcm_sample_t PCM_MAX = 16'sh7FFF;
    localparam pcm_sample_t PCM_MIN = 16'sh8000;

    function automatic pcm_sample_t sat16(input logic signed [25:0] v);
        if (v > 26'sd32767) begin
            return PCM_MAX;
        end
        if (v < -26'sd32768) begin
            return PCM_MIN;
        end
        return v[15:0];
    endfunction

    function automatic pcm_sample_t abs_sat16(input pcm_sample_t v);
        if (v == PCM_MIN) begin
            return PCM_MAX;
        end
        if (v[15]) begin
            return -v;
        end
        return v;
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// pcm_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// pop_data whenever empty=0; a pop advances to the next entry.
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : write push_data (ignored when full unless popping)
//   push_data    : write data
//   full         : DEPTH entries held
//   pop          : consume head entry (ignored when empty)
//   pop_data     : head entry, 0 when empty
//   empty        : no entries held
//   level        : current occupancy, 0..DEPTH
module pcm_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign do_pop   = pop & ~empty;
    // When full, a same-cycle pop frees the slot being written.
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcm_sample_conditioner.sv
// pcm_sample_conditioner
// DC removal (leaky integrator), Q4.4 gain with saturation and an output
// FWFT FIFO with valid/ready toward the consumer. Samples arriving while the
// FIFO is full are dropped and flagged in the sticky overflow bit.
// Optional feature macro: PCM_PEAK_METER_EN adds peak_level / peak_clear.
//   clk, reset_n    : clock and asynchronous active-low reset
//   in_pcm_data     : signed input sample, qualified by in_valid strobe
//   gain            : unsigned Q4.4 gain (0x10 = 1.0)
//   dc_bypass       : skip DC subtraction; estimator keeps tracking
//   out_pcm_data    : FIFO head sample, with out_valid / out_ready
//   fifo_level      : FIFO occupancy
//   overflow        : sticky drop flag, cleared by clear_overflow
//   peak_level      : max |sample| written (PCM_PEAK_METER_EN only)
//   peak_clear      : zero peak_level (PCM_PEAK_METER_EN only)
module pcm_sample_conditioner
    import pcm_cond_pkg::*;
#(
    parameter int DC_SHIFT   = 10,
    parameter int GAIN_FRAC  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  pcm_sample_t                   in_pcm_data,
    input  logic                          in_valid,
    input  logic [7:0]                    gain,
    input  logic                          dc_bypass,
    output pcm_sample_t                   out_pcm_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
`ifdef PCM_PEAK_METER_EN
    ,
    output logic [15:0]                   peak_level,
    input  logic                          peak_clear
`endif
);

    localparam int ACC_W = 16 + DC_SHIFT;

    // DC estimator
    logic signed [ACC_W-1:0] dc_acc;
    pcm_sample_t             dc_est;
    logic signed [16:0]      est_diff;

    assign dc_est   = dc_acc[ACC_W-1:DC_SHIFT];
    assign est_diff = {in_pcm_data[15], in_pcm_data} - {dc_est[15], dc_est};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dc_acc <= '0;
        end else if (in_valid) begin
            dc_acc <= dc_acc + {{(ACC_W-17){est_diff[16]}}, est_diff};
        end
    end

    // Stage 1: DC subtraction, 17-bit saturated
    pcm_sample_t        sub_val;
    logic signed [17:0] s1_wide;
    logic signed [16:0] s1_next;
    logic signed [16:0] s1_d;
    logic               s1_valid;

    assign sub_val = dc_bypass ? '0 : dc_est;
    assign s1_wide = {{2{in_pcm_data[15]}}, in_pcm_data} - {{2{sub_val[15]}}, sub_val};

    always_comb begin
        s1_next = s1_wide[16:0];
        if (s1_wide[17] != s1_wide[16]) begin
            s1_next = s1_wide[17] ? 17'sh10000 : 17'sh0FFFF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_d <= s1_next;
            end
        end
    end

    // Stage 2: gain, floor shift, 16-bit saturation
    logic signed [25:0] d_ext;
    logic signed [25:0] g_ext;
    logic signed [25:0] prod;
    logic signed [25:0] scaled;
    pcm_sample_t        s2_data;
    logic               s2_valid;

    assign d_ext  = {{9{s1_d[16]}}, s1_d};
    assign g_ext  = {18'd0, gain};
    assign prod   = d_ext * g_ext;
    assign scaled = prod >>> GAIN_FRAC;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat16(scaled);
            end
        end
    end

    // Stage 3: FIFO write with drop detection
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        push_ok;
    logic        drop;
    logic [15:0] head_data;

    assign pop     = out_valid & out_ready;
    assign push_ok = s2_valid & (~fifo_full | pop);
    assign drop    = s2_valid & fifo_full & ~pop;

    pcm_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (s2_data),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (head_data),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid    = ~fifo_empty;
    assign out_pcm_data = head_data;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef PCM_PEAK_METER_EN
    pcm_sample_t wr_abs;

    assign wr_abs = abs_sat16(s2_data);

    // A write coinciding with a clear reloads from the new sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_level <= '0;
        end else if (peak_clear) begin
            peak_level <= push_ok ? wr_abs : '0;
        end else if (push_ok && ($unsigned(wr_abs) > peak_level)) begin
            peak_level <= wr_abs;
        end
    end
`endif

endmodule

// File: tb/tb_pcm_sample_conditioner.sv
module tb_pcm_sample_conditioner;

    logic               clk;
    logic               reset_n;
    logic signed [15:0] in_pcm_data;
    logic               in_valid;
    logic [7:0]         gain;
    logic               dc_bypass;
    logic signed [15:0] out_pcm_data;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         fifo_level;
    logic               overflow;
    logic               clear_overflow;
`ifdef PCM_PEAK_METER_EN
    logic [15:0]        peak_level;
    logic               peak_clear;
`endif

    int tests = 0;
    int fails = 0;

    bit logging = 0;
    int pop_log[$];

    pcm_sample_conditioner #(
        .DC_SHIFT   (4),
        .GAIN_FRAC  (4),
        .FIFO_DEPTH (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_pcm_data    (in_pcm_data),
        .in_valid       (in_valid),
        .gain           (gain),
        .dc_bypass      (dc_bypass),
        .out_pcm_data   (out_pcm_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef PCM_PEAK_METER_EN
        ,
        .peak_level     (peak_level),
        .peak_clear     (peak_clear)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (logging && out_valid && out_ready) begin
            pop_log.push_back(int'(out_pcm_data));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int x);
        in_valid    = 1'b1;
        in_pcm_data = 16'(x);
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic run_one(input string tag, input int x, input logic [7:0] g, input int exp);
        gain = g;
        send(x);
        tick();
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, out_pcm_data, exp);
        tick();
    endtask

    initial begin
        int prev;
        int cur;
        int mono_bad;
        int valid_bad;
        int lvl_bad;
        int order_bad;
        int guard;

        reset_n        = 1'b0;
        in_pcm_data    = '0;
        in_valid       = 1'b0;
        gain           = 8'h10;
        dc_bypass      = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
`ifdef PCM_PEAK_METER_EN
        peak_clear     = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_pcm_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        tick();

        // DC removal, constant input 1000
        out_ready = 1'b1;
        prev      = 32'h4000_0000;
        mono_bad  = 0;
        valid_bad = 0;
        for (int i = 0; i < 200; i++) begin
            send(1000);
            tick();
            if (i == 0) chk("lat_n2", out_valid, 0);
            tick();
            if (i == 0) chk("lat_n3", out_valid, 1);
            if (out_valid !== 1'b1) valid_bad++;
            cur = int'(out_pcm_data);
            if (i == 0) chk("dc_first", cur, 1000);
            if (i == 1) chk("dc_second", cur, 938);
            if (i == 2) chk("dc_third", cur, 879);
            if (cur > prev) mono_bad++;
            prev = cur;
            tick();
        end
        chk("dc_valid", valid_bad, 0);
        chk("dc_mono", mono_bad, 0);
        chk("dc_settled", ((prev <= 16) && (prev >= -16)) ? 1 : 0, 1);

        // Gain, rounding and saturation with bypass
        dc_bypass = 1'b1;
        run_one("sat_pos", 20000, 8'h20, 32767);
        run_one("sat_neg", -20000, 8'h20, -32768);
        run_one("round_neg", -3, 8'h08, -2);
        run_one("round_pos", 7, 8'h18, 10);
        run_one("unity_min", -32768, 8'h10, -32768);
        run_one("gain_zero", 12345, 8'h00, 0);
        run_one("gain_max", -1, 8'hFF, -16);

        // Overflow: 17 strobes into a stalled FIFO
        gain      = 8'h10;
        out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            in_valid    = 1'b1;
            in_pcm_data = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("ovf_level", fifo_level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_pcm_data, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain", out_pcm_data, i);
            tick();
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_level", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Full FIFO with simultaneous push and pop every cycle
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid    = 1'b1;
            in_pcm_data = 16'(101 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("thru_fill", fifo_level, 16);
        pop_log.delete();
        logging = 1'b1;
        lvl_bad = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid    = 1'b1;
            in_pcm_data = 16'(117 + i);
            if (i == 2) out_ready = 1'b1;
            tick();
            if (fifo_level !== 5'd16) lvl_bad++;
        end
        in_valid = 1'b0;
        tick();
        if (fifo_level !== 5'd16) lvl_bad++;
        tick();
        if (fifo_level !== 5'd16) lvl_bad++;
        chk("thru_level", lvl_bad, 0);
        guard = 0;
        while (out_valid && guard < 40) begin
            tick();
            guard++;
        end
        chk("thru_drain_bound", out_valid, 0);
        logging = 1'b0;
        chk("thru_no_drop", overflow, 0);
        chk("thru_count", pop_log.size(), 32);
        order_bad = 0;
        foreach (pop_log[k]) begin
            if (pop_log[k] != 101 + k) order_bad++;
        end
        chk("thru_order", order_bad, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            in_pcm_data = 16'(11 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_level", fifo_level, 5);
        send(77);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_pcm_data, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_overflow", overflow, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_inflight", out_valid, 0);
        out_ready = 1'b1;
        gain      = 8'h10;
        dc_bypass = 1'b1;
        send(500);
        tick();
        chk("post_rst_n2", out_valid, 0);
        tick();
        chk("post_rst_n3", out_valid, 1);
        chk("post_rst_data", out_pcm_data, 500);
        tick();

`ifdef PCM_PEAK_METER_EN
        chk("peak_rst", peak_level, 0);
        send(-32768);
        tick();
        tick();
        chk("peak_min", peak_level, 32767);
        tick();
        send(100);
        tick();
        tick();
        chk("peak_hold", peak_level, 32767);
        tick();
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        chk("peak_cleared", peak_level, 0);
        send(-7);
        tick();
        tick();
        chk("peak_neg7", peak_level, 7);
        tick();
        send(3);
        tick();
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        chk("peak_clear_write", peak_level, 3);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
